// File: rtl/pixel_stream_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_rx_if
// Brief    : Pixel stream receive bus. Carries the incoming shade/sof/eol
//            stream and the registered, coordinate-tagged output stream.
//            The slave modport is the receiver's view; master is the view of
//            the surrounding source/consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_stream_rx_if #(
    parameter int OUT_WIDTH = 24,
    parameter int X_W       = 10,
    parameter int Y_W       = 9
);
    logic [OUT_WIDTH-1:0] s_data;
    logic                 s_valid;
    logic                 s_sof;
    logic                 s_eol;
    logic                 s_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic [X_W-1:0]       m_x;
    logic [Y_W-1:0]       m_y;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output s_data, s_valid, s_sof, s_eol,
        input  s_ready,
        input  m_data, m_x, m_y, m_valid,
        output m_ready
    );

    modport slave (
        input  s_data, s_valid, s_sof, s_eol,
        output s_ready,
        output m_data, m_x, m_y, m_valid,
        input  m_ready
    );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_rx.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_rx
// Brief    : Pixel stream receiver. Rebuilds (x, y) for every pixel, checks
//            sof/eol framing, resynchronises after framing errors and forwards
//            pixels through one registered, full-throughput output stage.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_stream_rx #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int OUT_WIDTH     = 24
) (
    input  logic                clk,
    input  logic                rst,
    pixel_stream_rx_if.slave    bus,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic [3:0]          err_status,
    input  logic                err_clear
);

    // A 1-pixel-wide or 1-line-high screen still needs a 1-bit counter.
    localparam int c_X_W = ($clog2(SCREEN_WIDTH)  < 1) ? 1 : $clog2(SCREEN_WIDTH);
    localparam int c_Y_W = ($clog2(SCREEN_HEIGHT) < 1) ? 1 : $clog2(SCREEN_HEIGHT);
    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(SCREEN_WIDTH - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(SCREEN_HEIGHT - 1);

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_X_W-1:0]     r_x;
    logic [c_Y_W-1:0]     r_y;
    logic [c_X_W-1:0]     w_x_nxt;
    logic [c_Y_W-1:0]     w_y_nxt;

    logic [OUT_WIDTH-1:0] r_m_data;
    logic [c_X_W-1:0]     r_m_x;
    logic [c_Y_W-1:0]     r_m_y;
    logic                 r_m_valid;
    logic                 r_frame_done;
    logic [15:0]          r_frame_count;
    logic [3:0]           r_err;

    logic                 w_s_ready;
    logic                 w_accept;
    logic                 w_emit;
    logic                 w_at_origin;
    logic                 w_load;
    logic [c_X_W-1:0]     w_out_x;
    logic [c_Y_W-1:0]     w_out_y;
    logic                 w_line_end;
    logic                 w_frame_end;
    logic [3:0]           w_err_set;

    // Single-entry pipeline: room whenever the held beat is empty or leaving.
    assign w_s_ready   = !r_m_valid || bus.m_ready;
    assign w_accept    = bus.s_valid && w_s_ready;
    assign w_emit      = r_m_valid && bus.m_ready;
    assign w_at_origin = (r_x == '0) && (r_y == '0);

    // Framing checks, output coordinate selection and coordinate advance.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_load      = 1'b0;
        w_out_x     = r_x;
        w_out_y     = r_y;
        w_line_end  = 1'b0;
        w_frame_end = 1'b0;
        w_err_set   = 4'b0000;

        if (w_accept) begin
            case (r_state)
                ST_WAIT_SOF: begin
                    // Everything before the first sof is silently discarded.
                    if (bus.s_sof) begin
                        w_load      = 1'b1;
                        w_out_x     = '0;
                        w_out_y     = '0;
                        w_line_end  = (c_X_LAST == '0);
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!bus.s_sof && w_at_origin) begin
                        // Lost frame start: drop and hunt for the next sof.
                        w_err_set[1] = 1'b1;
                        w_state_nxt  = ST_WAIT_SOF;
                    end else begin
                        w_load = 1'b1;
                        if (bus.s_sof && !w_at_origin) begin
                            // Unexpected sof: trust the source and restart at (0,0).
                            w_err_set[0] = 1'b1;
                            w_out_x      = '0;
                            w_out_y      = '0;
                        end
                        if (bus.s_eol && (w_out_x != c_X_LAST)) begin
                            w_err_set[2] = 1'b1;
                        end
                        if (!bus.s_eol && (w_out_x == c_X_LAST)) begin
                            w_err_set[3] = 1'b1;
                        end
                        w_line_end = bus.s_eol || (w_out_x == c_X_LAST);
                    end
                end
                default: begin
                    w_state_nxt = ST_WAIT_SOF;
                end
            endcase
        end

        if (w_load) begin
            if (w_line_end) begin
                w_x_nxt = '0;
                if (w_out_y == c_Y_LAST) begin
                    w_y_nxt     = '0;
                    w_frame_end = 1'b1;
                end else begin
                    w_y_nxt = w_out_y + 1'b1;
                end
            end else begin
                w_x_nxt = w_out_x + 1'b1;
                w_y_nxt = w_out_y;
            end
        end
    end

    // Receiver state and expected-coordinate counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_WAIT_SOF;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // Output register: load wins over emit so back-to-back beats stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_data  <= '0;
            r_m_x     <= '0;
            r_m_y     <= '0;
            r_m_valid <= 1'b0;
        end else if (w_load) begin
            r_m_data  <= bus.s_data;
            r_m_x     <= w_out_x;
            r_m_y     <= w_out_y;
            r_m_valid <= 1'b1;
        end else if (w_emit) begin
            r_m_valid <= 1'b0;
        end
    end

    // Frame completion pulse/counter and sticky error bits (new sets beat clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err         <= '0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (err_clear) begin
                r_err <= w_err_set;
            end else begin
                r_err <= r_err | w_err_set;
            end
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.m_data   = r_m_data;
    assign bus.m_x      = r_m_x;
    assign bus.m_y      = r_m_y;
    assign bus.m_valid  = r_m_valid;
    assign frame_done   = r_frame_done;
    assign frame_count  = r_frame_count;
    assign err_status   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_rx
// Brief    : Self-checking bench for pixel_stream_rx on a 4x3 screen. A
//            raster-index reference model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_rx;

    localparam int c_W  = 4;
    localparam int c_H  = 3;
    localparam int c_OW = 24;

    logic        clk;
    logic        rst;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [3:0]  err_status;
    logic        err_clear;

    pixel_stream_rx_if #(.OUT_WIDTH(c_OW), .X_W(2), .Y_W(2)) bus ();

    pixel_stream_rx #(
        .SCREEN_WIDTH  (c_W),
        .SCREEN_HEIGHT (c_H),
        .OUT_WIDTH     (c_OW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err_status  (err_status),
        .err_clear   (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: pos is the raster index of the next expected pixel.
    bit          exp_valid;
    logic [23:0] exp_data;
    int          exp_x, exp_y;
    bit          exp_fd;
    int          exp_fc;
    logic [3:0]  exp_err;
    bit          synced;
    int          pos;
    bit          last_acc;

    int mr_mode;   // 0: always ready, 1: toggle every 2 cycles, 2: random
    bit gap_mode;  // randomly withhold s_valid
    int cyc_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_valid = 0; exp_data = '0; exp_x = 0; exp_y = 0;
        exp_fd = 0; exp_fc = 0; exp_err = '0; synced = 0; pos = 0;
    endtask

    task automatic model_step(input bit v, input logic [23:0] d, input bit sof,
                              input bit eol, input bit mr, input bit clr);
        bit rdy, acc, ld, le;
        int cx, cy, ox, oy;
        rdy = !exp_valid || mr;
        acc = v && rdy;
        last_acc = acc;
        exp_fd = 0;
        if (clr) exp_err = '0;
        if (exp_valid && mr) exp_valid = 0;
        if (acc) begin
            cx = pos % c_W; cy = pos / c_W;
            ld = 0; le = 0; ox = 0; oy = 0;
            if (!synced) begin
                if (sof) begin
                    ld = 1; synced = 1; le = (c_W == 1);
                end
            end else if (!sof && pos == 0) begin
                exp_err[1] = 1'b1;
                synced = 0;
            end else begin
                ld = 1;
                if (sof && pos != 0) begin
                    exp_err[0] = 1'b1;
                end else begin
                    ox = cx; oy = cy;
                end
                if (eol && ox != c_W - 1) exp_err[2] = 1'b1;
                if (!eol && ox == c_W - 1) exp_err[3] = 1'b1;
                le = eol || (ox == c_W - 1);
            end
            if (ld) begin
                exp_valid = 1; exp_data = d; exp_x = ox; exp_y = oy;
                if (le) begin
                    pos = ((oy + 1) % c_H) * c_W;
                    if (oy == c_H - 1) begin
                        exp_fd = 1;
                        exp_fc = (exp_fc + 1) % 65536;
                    end
                end else begin
                    pos = oy * c_W + ox + 1;
                end
            end
        end
    endtask

    function automatic bit pick_mr();
        if (mr_mode == 0) return 1'b1;
        if (mr_mode == 1) return ((cyc_cnt / 2) % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive, check current outputs against model, advance model.
    task automatic cycle(input bit v, input logic [23:0] d, input bit sof,
                         input bit eol, input bit mr, input bit clr);
        bus.s_valid = v; bus.s_data = d; bus.s_sof = sof; bus.s_eol = eol;
        bus.m_ready = mr; err_clear = clr;
        #3;
        check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("m_data", 32'(bus.m_data), 32'(exp_data));
            check("m_x", 32'(bus.m_x), 32'(exp_x));
            check("m_y", 32'(bus.m_y), 32'(exp_y));
        end
        check("s_ready", 32'(bus.s_ready), 32'(!exp_valid || mr));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("frame_count", 32'(frame_count), 32'(exp_fc));
        check("err_status", 32'(err_status), 32'(exp_err));
        model_step(v, d, sof, eol, mr, clr);
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, pick_mr(), 1'b0);
    endtask

    // Offer one beat until the model says it was accepted (bounded).
    task automatic beat(input logic [23:0] d, input bit sof, input bit eol);
        int  tries;
        bit  v;
        tries = 0;
        last_acc = 0;
        while (!last_acc) begin
            v = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(v, d, sof, eol, pick_mr(), 1'b0);
            tries++;
            if (!last_acc && tries > 64) begin
                checks++; errors++;
                $error("FAIL beat_timeout observed=%0d expected=accept", tries);
                last_acc = 1;
            end
        end
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < c_W * c_H; i++)
            beat(24'(base + i + 1), i == 0, (i % c_W) == c_W - 1);
    endtask

    initial begin
        bit sof, eol;
        mr_mode = 0; gap_mode = 0; cyc_cnt = 0;
        rst = 1'b0; err_clear = 1'b0;
        bus.s_valid = 0; bus.s_data = '0; bus.s_sof = 0; bus.s_eol = 0; bus.m_ready = 1;
        model_reset();
        @(posedge clk); #1;
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_m_data", 32'(bus.m_data), 0);
        check("rst_m_xy", 32'({bus.m_x, bus.m_y}), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_err", 32'(err_status), 0);
        rst = 1'b1;

        // Junk before the first sof is dropped without error.
        for (int i = 0; i < 5; i++) beat(24'(100 + i), 1'b0, 1'b0);
        check("junk_no_valid", 32'(bus.m_valid), 0);
        send_frame(0);
        idle(2);
        check("clean_frame_count", 32'(frame_count), 1);
        check("clean_err", 32'(err_status), 0);

        // Same frame under toggling backpressure.
        mr_mode = 1;
        send_frame(0);
        idle(4);
        mr_mode = 0;
        check("stall_frame_count", 32'(frame_count), 2);

        // Early eol on row 0, then an unexpected sof at (2,1), then clear.
        beat(24'h11, 1'b1, 1'b0);
        beat(24'h12, 1'b0, 1'b1);
        idle(1);
        check("eol_early_err", 32'(err_status), 32'h4);
        beat(24'h13, 1'b0, 1'b0);
        beat(24'h14, 1'b0, 1'b0);
        beat(24'h15, 1'b1, 1'b0);
        idle(1);
        check("sof_early_err", 32'(err_status), 32'h5);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("err_cleared", 32'(err_status), 0);

        // Missing eol at x=3 on row 0, rest of frame clean, then no sof.
        beat(24'h21, 1'b0, 1'b0);
        beat(24'h22, 1'b0, 1'b0);
        beat(24'h23, 1'b0, 1'b0);
        for (int i = 0; i < 2 * c_W; i++) beat(24'(8'h30 + i), 1'b0, (i % c_W) == c_W - 1);
        idle(1);
        check("eol_missing_err", 32'(err_status), 32'h8);
        beat(24'h40, 1'b0, 1'b0);
        idle(1);
        check("sof_missing_err", 32'(err_status), 32'hA);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Random frames with random gaps, backpressure and framing faults.
        mr_mode = 2; gap_mode = 1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < c_W * c_H; i++) begin
                sof = (i == 0);
                eol = (i % c_W) == c_W - 1;
                if ($urandom_range(0, 15) == 0) sof = !sof;
                if ($urandom_range(0, 15) == 0) eol = !eol;
                beat(24'($urandom), sof, eol);
            end
        end
        idle(4);
        mr_mode = 0; gap_mode = 0;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset while beat 7 is held in the output register.
        send_frame(0);
        for (int i = 0; i < 7; i++) beat(24'(50 + i), i == 0, (i % c_W) == c_W - 1);
        bus.s_valid = 0; bus.m_ready = 0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_m_valid", 32'(bus.m_valid), 0);
        check("arst_frame_count", 32'(frame_count), 0);
        check("arst_err", 32'(err_status), 0);
        check("arst_s_ready", 32'(bus.s_ready), 1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        send_frame(200);
        idle(2);
        check("post_rst_frame_count", 32'(frame_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_stream_rx.md
Name: pixel_stream_rx

Overview:
- Receive side of the pixel video stream protocol: consumes the shade/sof/eol/valid/ready stream produced by the ray-marcher output stage.
- Reconstructs each pixel's (x, y) screen coordinate and checks frame/line framing.
- Forwards pixel data with coordinates through a single registered stage to downstream consumers (framebuffer writer, checksum/verification taps).
- Resynchronises to the stream after framing errors and reports them as sticky status bits.

Parameters:
- SCREEN_WIDTH, 640, pixels per line.
- SCREEN_HEIGHT, 480, lines per frame.
- OUT_WIDTH, 24, pixel data width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  OUT_WIDTH  incoming pixel shade.
- s_valid  in  1  incoming beat valid.
- s_sof  in  1  start of frame, asserted on pixel (0,0).
- s_eol  in  1  end of line, asserted on pixel x = SCREEN_WIDTH-1.
- s_ready  out  1  receiver can accept a beat.
- m_data  out  OUT_WIDTH  registered pixel shade.
- m_x  out  $clog2(SCREEN_WIDTH)  pixel column.
- m_y  out  $clog2(SCREEN_HEIGHT)  pixel row.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts output beat.
- frame_done  out  1  one-cycle pulse on acceptance of pixel (W-1, H-1).
- frame_count  out  16  completed frames, wraps at 2^16.
- err_status  out  4  sticky errors: [0] sof_early, [1] sof_missing, [2] eol_early, [3] eol_missing.
- err_clear  in  1  synchronous clear of err_status.

Behaviour:
- Accept: a beat is accepted when s_valid && s_ready. A beat is emitted when m_valid && m_ready.
- s_ready = !m_valid || m_ready. It is combinational, and s_ready is always 1 in WAIT_SOF.
- Output register: an accepted, non-dropped beat loads m_data/m_x/m_y and sets m_valid on the next edge, giving latency 1 cycle and full throughput.
- m_valid clears on emit when no new beat loads in the same cycle. m_data/m_x/m_y hold stable while m_valid && !m_ready.
- Reset values: all outputs 0, state WAIT_SOF, internal x = y = 0. Reset mid-frame discards the held beat and all in-flight data.
- FSM states:
  - WAIT_SOF: beats with s_sof=0 are accepted and dropped, with no output and no error. A beat with s_sof=1 is output as (0,0); next expected is (1,0) (or (0,1) when SCREEN_WIDTH=1); go to RUN.
  - RUN: each accepted beat is output at the expected coordinate (x, y), then the coordinate advances per the rules below.
- RUN checks, in priority order, for each accepted beat:
  1. s_sof=1 and (x,y)≠(0,0): set sof_early. The beat is output as (0,0) and the counters resync to (1,0).
  2. s_sof=0 and (x,y)=(0,0): set sof_missing. The beat is dropped; go to WAIT_SOF.
  3. s_eol=1 and x≠W-1: set eol_early. The beat is output at (x,y); next x=0 and y advances with wrap.
  4. s_eol=0 and x=W-1: set eol_missing. The beat is output at (x,y) and wraps normally.
- Coordinate advance:
  - x = W-1 → x=0, y=y+1.
  - y = H-1 at line end → y=0.
  - Otherwise x=x+1.
- Checks 3/4 also apply to the sof_early resync beat, evaluated at x=0.
- frame_done: pulses for one cycle in the cycle after acceptance of the beat output at (W-1, H-1). frame_count increments on the same edge. An eol_early on the last row that wraps y also counts as a frame end.
- err_status: bits are sticky. err_clear clears them; a set in the same cycle as err_clear wins.
- Simultaneous load and emit in the same cycle: the new beat replaces the output register and m_valid stays 1.
- Widths: x/y counters are exactly $clog2 wide, with no overflow beyond W-1/H-1.

Test Plan:
- W=4, H=3, clean frame of 12 beats with data 1..12, m_ready=1 → outputs (0,0)..(3,2) in raster order, data 1..12, each 1 cycle after accept; frame_done pulse once after beat 12; frame_count=1; err_status=0.
- Same frame with m_ready toggling 1/0 every 2 cycles → no beat lost or duplicated, m_data stable while stalled, s_ready=0 exactly when m_valid && !m_ready.
- 5 beats with sof=0 before the first sof → all 5 accepted and dropped with m_valid never set; sof beat emerges as (0,0); err_status=0.
- eol asserted at x=1 on row 0 → that beat output at (1,0), next beat at (0,1), err_status=4'b0100. sof asserted mid-row at (2,1) → output (0,0), err_status[0]=1. err_clear pulsed → err_status=0.
- Row missing eol at x=3 → beat output (3,y), next beat (0,y+1), err_status[3]=1. First beat of the next frame with sof=0 → dropped, err_status[1]=1, receiver back in WAIT_SOF.
- Reset asserted asynchronously at beat 7 with m_valid=1 → m_valid=0 immediately, frame_count=0. After release, the next sof frame decodes from (0,0) correctly.
